// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Independent safety monitor on the NS/EW light outputs of an intersection
//   controller. It decodes the one-hot light pair into a phase and checks the
//   encoding, conflicts, the phase sequence and each phase's duration. The
//   first fault is latched, and completed light cycles are counted.
//
//   Pipeline: stage 1 registers ns/ew. Stage 2 checks the registered pair and
//   updates the FSM and outputs. An input sampled at edge N is reflected in
//   the outputs after edge N+1.
//
//   Optional feature macro: TLM_FAILSAFE_EN. When it is defined, the module
//   adds ns_safe/ew_safe. These outputs repeat the registered lights, or
//   force RED on both sides while a fault is latched.
//
// Ports
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-high reset
//   ns           in   3      NS lights: 100 RED, 010 YELLOW, 001 GREEN
//   ew           in   3      EW lights, same encoding
//   clr_fault    in   1      single-cycle pulse: clear latched fault, resync
//   phase        out  2      decoded phase of the last legal sample
//   phase_valid  out  1      high while tracking a legal phase sequence
//   fault        out  1      sticky fault flag
//   fault_code   out  3      0 none,1 encoding,2 conflict,3 sequence,4 short,5 long
//   cycle_count  out  CNT_W  completed P3->P0 transitions (wraps)
//   ns_safe      out  3      (TLM_FAILSAFE_EN only) fail-safe NS lights
//   ew_safe      out  3      (TLM_FAILSAFE_EN only) fail-safe EW lights
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 6,
  parameter int GREEN_MAX  = 6,
  parameter int YELLOW_MIN = 3,
  parameter int YELLOW_MAX = 3,
  parameter int DUR_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ns,
  input  logic [2:0]       ew,
  input  logic             clr_fault,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] cycle_count
`ifdef TLM_FAILSAFE_EN
  ,
  output logic [2:0]       ns_safe,
  output logic [2:0]       ew_safe
`endif
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_ENC   = 3'd1;
  localparam logic [2:0] FC_CONF  = 3'd2;
  localparam logic [2:0] FC_SEQ   = 3'd3;
  localparam logic [2:0] FC_SHORT = 3'd4;
  localparam logic [2:0] FC_LONG  = 3'd5;

  localparam logic [DUR_W-1:0] G_MIN   = DUR_W'(GREEN_MIN);
  localparam logic [DUR_W-1:0] G_MAX   = DUR_W'(GREEN_MAX);
  localparam logic [DUR_W-1:0] Y_MIN   = DUR_W'(YELLOW_MIN);
  localparam logic [DUR_W-1:0] Y_MAX   = DUR_W'(YELLOW_MAX);
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // The duration counter sticks at all-ones instead of wrapping.
  function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] d);
    return (&d) ? d : d + DUR_ONE;
  endfunction

  // Exactly one code survives. The code is chosen in priority order.
  function automatic logic [2:0] pick_code(input logic conf, input logic enc,
                                           input logic seq, input logic lng,
                                           input logic shrt);
    if (conf)      return FC_CONF;
    else if (enc)  return FC_ENC;
    else if (seq)  return FC_SEQ;
    else if (lng)  return FC_LONG;
    else if (shrt) return FC_SHORT;
    else           return FC_NONE;
  endfunction

  logic [2:0]       ns_p1, ew_p1;
  logic             vld_p1;

  state_t           state;
  logic [DUR_W-1:0] dur_p2;
  logic             partial_p2;

  logic             ns_oh, ew_oh;
  logic             enc_err, conf_err;
  logic             is_phase;
  logic [1:0]       dec_phase;
  logic             is_same, is_step;
  logic [DUR_W-1:0] dur_inc;
  logic [DUR_W-1:0] cur_min, cur_max;
  logic             long_err, short_err, seq_err;
  logic [2:0]       code_sel;

  // ---- stage 1: register the light pair ----
  // vld_p1 masks the first check after reset, when ns_p1/ew_p1 have not yet
  // captured a real sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= 1'b1;
  end

  always_ff @(posedge clk) begin
    ns_p1 <= ns;
    ew_p1 <= ew;
  end

  // ---- stage 2: checks on the registered pair ----
  assign ns_oh    = (ns_p1 == RED) || (ns_p1 == YEL) || (ns_p1 == GRN);
  assign ew_oh    = (ew_p1 == RED) || (ew_p1 == YEL) || (ew_p1 == GRN);
  assign enc_err  = !(ns_oh && ew_oh);
  assign conf_err = ns_oh && ew_oh && (ns_p1 != RED) && (ew_p1 != RED);

  // All-red is valid encoding but is not a phase. It is caught as a sequence error.
  always_comb begin
    is_phase  = 1'b0;
    dec_phase = 2'd0;
    case ({ns_p1, ew_p1})
      {GRN, RED}: begin is_phase = 1'b1; dec_phase = 2'd0; end
      {YEL, RED}: begin is_phase = 1'b1; dec_phase = 2'd1; end
      {RED, GRN}: begin is_phase = 1'b1; dec_phase = 2'd2; end
      {RED, YEL}: begin is_phase = 1'b1; dec_phase = 2'd3; end
      default:    begin is_phase = 1'b0; dec_phase = 2'd0; end
    endcase
  end

  assign is_same   = is_phase && (dec_phase == phase);
  assign is_step   = is_phase && (dec_phase == phase + 2'd1);
  assign dur_inc   = dur_sat_inc(dur_p2);
  // Even phases are green and odd phases are yellow.
  assign cur_min   = phase[0] ? Y_MIN : G_MIN;
  assign cur_max   = phase[0] ? Y_MAX : G_MAX;
  assign long_err  = is_same && (dur_inc > cur_max);
  // The phase locked from INIT may have been entered mid-way, so its
  // minimum-duration check is skipped.
  assign short_err = is_step && !partial_p2 && (dur_p2 < cur_min);
  assign seq_err   = !is_same && !is_step;

  always_comb begin
    code_sel = FC_NONE;
    if (state == S_TRACK)
      code_sel = pick_code(conf_err, enc_err, seq_err, long_err, short_err);
    else if (state == S_INIT)
      code_sel = pick_code(conf_err, enc_err, 1'b0, 1'b0, 1'b0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      phase       <= 2'd0;
      phase_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      cycle_count <= '0;
      dur_p2      <= '0;
      partial_p2  <= 1'b0;
    end else if (clr_fault) begin
      // clr_fault overrides any fault detected in this same cycle.
      state       <= S_INIT;
      phase_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      dur_p2      <= '0;
      partial_p2  <= 1'b0;
    end else if (vld_p1) begin
      case (state)
        S_INIT: begin
          if (code_sel != FC_NONE) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= code_sel;
          end else if (is_phase) begin
            state       <= S_TRACK;
            phase       <= dec_phase;
            phase_valid <= 1'b1;
            dur_p2      <= DUR_ONE;
            partial_p2  <= 1'b1;
          end
        end
        S_TRACK: begin
          if (code_sel != FC_NONE) begin
            state       <= S_FAULT;
            phase_valid <= 1'b0;
            fault       <= 1'b1;
            fault_code  <= code_sel;
          end else if (is_same) begin
            dur_p2 <= dur_inc;
          end else begin
            phase      <= dec_phase;
            dur_p2     <= DUR_ONE;
            partial_p2 <= 1'b0;
            if (phase == 2'd3) cycle_count <= cycle_count + CNT_ONE;
          end
        end
        S_FAULT: begin
          // Frozen until clr_fault or reset.
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef TLM_FAILSAFE_EN
  logic fault_nxt;

  // Mirrors the next value of fault so the safe lights change in step with it.
  assign fault_nxt = !clr_fault &&
                     ((state == S_FAULT) || (vld_p1 && (code_sel != FC_NONE)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ns_safe <= RED;
      ew_safe <= RED;
    end else if (fault_nxt || !vld_p1) begin
      ns_safe <= RED;
      ew_safe <= RED;
    end else begin
      ns_safe <= ns_p1;
      ew_safe <= ew_p1;
    end
  end
`endif

endmodule
